data_io_stream: RTL and testbench

- Next-generation IO-controller download client. Receives the file-download SPI protocol from the IO controller and presents the file as a write stream to core memory.
- Unlike the previous SPI-clocked version, it runs entirely in the core clock domain, oversampling SCK.
- Adds parametrised address and data width, file-index capture, a 2-entry write FIFO with back-pressure, byte count and overflow reporting.
- Sits between the MiST SPI pins and the core ROM/RAM loader.

---
 rtl/data_io_stream.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_data_io_stream.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_stream.sv
// data_io_stream
// IO-controller file-download client. Decodes the download SPI protocol by
// oversampling SCK in the core clock domain and presents the downloaded file
// as a write stream (addr/dout/wr) with sink back-pressure.
//
// Parameters
//   AW          width of write address and byte-size counter
//   DW          write data width, 8 or 16 (16 packs bytes little-endian)
//   START_ADDR  first write address after a download start
//
// Ports
//   clk          core clock, at least 4x SCK
//   reset_n      asynchronous active-low reset
//   sck/ss/sdi   SPI pins from the IO controller, asynchronous to clk
//   downloading  high while a transfer is active or its writes still drain
//   index        file index from the last FILE_INDEX command
//   size         bytes accepted in the current/last download, saturating
//   wr/addr/dout one-cycle write strobe with address and data
//   wait_req     sink back-pressure; no wr is issued while high
//   overflow     sticky: a word was dropped because the write FIFO was full

module data_io_stream #(
   parameter int unsigned   AW         = 16,
   parameter int unsigned   DW         = 8,
   parameter logic [AW-1:0] START_ADDR = '0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          sck,
   input  logic          ss,
   input  logic          sdi,
   output logic          downloading,
   output logic [7:0]    index,
   output logic [AW-1:0] size,
   output logic          wr,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] dout,
   input  logic          wait_req,
   output logic          overflow
);

   localparam logic [7:0]    CmdFileTx    = 8'h53;
   localparam logic [7:0]    CmdFileTxDat = 8'h54;
   localparam logic [7:0]    CmdFileIndex = 8'h55;
   localparam logic [AW-1:0] AddrStep     = AW'(DW / 8);

   // ---------------------------------------------------------------------
   // Input synchronisers
   // ---------------------------------------------------------------------
   logic sck_s1_q, sck_s2_q, sck_h_q;
   logic ss_s1_q, ss_s2_q;
   logic sdi_s1_q, sdi_s2_q;
   logic sck_rise;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_s1_q <= 1'b0;
         sck_s2_q <= 1'b0;
         sck_h_q  <= 1'b0;
         ss_s1_q  <= 1'b1;
         ss_s2_q  <= 1'b1;
         sdi_s1_q <= 1'b0;
         sdi_s2_q <= 1'b0;
      end else begin
         sck_s1_q <= sck;
         sck_s2_q <= sck_s1_q;
         sck_h_q  <= sck_s2_q;
         ss_s1_q  <= ss;
         ss_s2_q  <= ss_s1_q;
         sdi_s1_q <= sdi;
         sdi_s2_q <= sdi_s1_q;
      end
   end

   // sdi travels through the same depth as sck, so sdi_s2_q is the bit
   // that was on the wire when SCK rose.
   assign sck_rise = sck_s2_q & ~sck_h_q;

   // ---------------------------------------------------------------------
   // Protocol, packer and write-FIFO state
   // ---------------------------------------------------------------------
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [6:0]    shift_q, shift_d;
   logic          is_cmd_q, is_cmd_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    index_q, index_d;
   logic [AW-1:0] size_q, size_d;
   logic          overflow_q, overflow_d;
   logic          downloading_q, downloading_d;
   logic          ending_q, ending_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          pack_full_q, pack_full_d;
   logic [7:0]    pack_lo_q, pack_lo_d;
   logic          push_q, push_d;
   logic [AW-1:0] push_addr_q, push_addr_d;
   logic [DW-1:0] push_data_q, push_data_d;

   logic [AW-1:0] mem_addr_q [2];
   logic [AW-1:0] mem_addr_d [2];
   logic [DW-1:0] mem_data_q [2];
   logic [DW-1:0] mem_data_d [2];
   logic          wptr_q, wptr_d;
   logic          rptr_q, rptr_d;
   logic [1:0]    fifo_cnt_q, fifo_cnt_d;

   logic [7:0]    byte_val;
   logic          byte_done;
   logic          pop;
   logic          fifo_full;
   logic          fifo_wr;

   // Write FIFO control. A push into a full FIFO is accepted if the head is
   // popped in the same cycle.
   always_comb begin
      pop        = (fifo_cnt_q != 2'd0) && !wait_req;
      fifo_full  = (fifo_cnt_q == 2'd2) && !pop;
      fifo_wr    = push_q && !fifo_full;
      fifo_cnt_d = fifo_cnt_q;
      unique case ({fifo_wr, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
      wptr_d     = fifo_wr ? ~wptr_q : wptr_q;
      rptr_d     = pop ? ~rptr_q : rptr_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      if (fifo_wr) begin
         mem_addr_d[wptr_q] = push_addr_q;
         mem_data_d[wptr_q] = push_data_q;
      end
   end

   // Byte assembly, command decode and packing.
   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      is_cmd_d      = is_cmd_q;
      cmd_d         = cmd_q;
      index_d       = index_q;
      size_d        = size_q;
      overflow_d    = overflow_q;
      downloading_d = downloading_q;
      ending_d      = ending_q;
      addr_d        = addr_q;
      pack_full_d   = pack_full_q;
      pack_lo_d     = pack_lo_q;
      push_d        = 1'b0;
      push_addr_d   = push_addr_q;
      push_data_d   = push_data_q;
      byte_val      = {shift_q, sdi_s2_q};
      byte_done     = 1'b0;

      if (ss_s2_q) begin
         bit_cnt_d = 3'd0;
         is_cmd_d  = 1'b1;
      end else if (sck_rise) begin
         shift_d   = byte_val[6:0];
         bit_cnt_d = bit_cnt_q + 3'd1;
         byte_done = (bit_cnt_q == 3'd7);
      end

      // Finish a download once every word, including a flushed partial one,
      // has left the FIFO. A start in the same cycle overrides this below.
      if (ending_q && (fifo_cnt_q == 2'd0) && !push_q) begin
         downloading_d = 1'b0;
         ending_d      = 1'b0;
      end

      if (byte_done) begin
         if (is_cmd_q) begin
            cmd_d    = byte_val;
            is_cmd_d = 1'b0;
         end else begin
            case (cmd_q)
               CmdFileTx: begin
                  if (byte_val[0]) begin
                     addr_d        = START_ADDR;
                     size_d        = '0;
                     overflow_d    = 1'b0;
                     pack_full_d   = 1'b0;
                     downloading_d = 1'b1;
                     ending_d      = 1'b0;
                  end else if (downloading_q) begin
                     ending_d = 1'b1;
                     if (pack_full_q) begin
                        push_d      = 1'b1;
                        push_addr_d = addr_q;
                        push_data_d = DW'(pack_lo_q);
                        addr_d      = addr_q + AddrStep;
                        pack_full_d = 1'b0;
                     end
                  end
               end
               CmdFileTxDat: begin
                  if (downloading_q) begin
                     if (size_q != {AW{1'b1}}) begin
                        size_d = size_q + AW'(1);
                     end
                     if ((DW == 16) && !pack_full_q) begin
                        pack_lo_d   = byte_val;
                        pack_full_d = 1'b1;
                     end else begin
                        push_d      = 1'b1;
                        push_addr_d = addr_q;
                        push_data_d = (DW == 16) ? DW'({byte_val, pack_lo_q}) : DW'(byte_val);
                        addr_d      = addr_q + AddrStep;
                        pack_full_d = 1'b0;
                     end
                  end
               end
               CmdFileIndex: index_d = byte_val;
               default: ;
            endcase
         end
      end

      // The address has already advanced for a dropped word.
      if (push_q && fifo_full) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_q     <= 3'd0;
         shift_q       <= 7'd0;
         is_cmd_q      <= 1'b1;
         cmd_q         <= 8'd0;
         index_q       <= 8'd0;
         size_q        <= '0;
         overflow_q    <= 1'b0;
         downloading_q <= 1'b0;
         ending_q      <= 1'b0;
         addr_q        <= START_ADDR;
         pack_full_q   <= 1'b0;
         pack_lo_q     <= 8'd0;
         push_q        <= 1'b0;
         push_addr_q   <= '0;
         push_data_q   <= '0;
         mem_addr_q[0] <= '0;
         mem_addr_q[1] <= '0;
         mem_data_q[0] <= '0;
         mem_data_q[1] <= '0;
         wptr_q        <= 1'b0;
         rptr_q        <= 1'b0;
         fifo_cnt_q    <= 2'd0;
      end else begin
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         is_cmd_q      <= is_cmd_d;
         cmd_q         <= cmd_d;
         index_q       <= index_d;
         size_q        <= size_d;
         overflow_q    <= overflow_d;
         downloading_q <= downloading_d;
         ending_q      <= ending_d;
         addr_q        <= addr_d;
         pack_full_q   <= pack_full_d;
         pack_lo_q     <= pack_lo_d;
         push_q        <= push_d;
         push_addr_q   <= push_addr_d;
         push_data_q   <= push_data_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_q    <= mem_data_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
      end
   end

   assign downloading = downloading_q;
   assign index       = index_q;
   assign size        = size_q;
   assign overflow    = overflow_q;
   assign wr          = pop;
   assign addr        = mem_addr_q[rptr_q];
   assign dout        = mem_data_q[rptr_q];

endmodule

// File: tb/tb_data_io_stream.sv
// Testbench for data_io_stream: three instances (DW=8, DW=16 at 0x100, AW=4)
// share one SPI driver, selected by sel; all writes are logged by a monitor
// and compared against hand-computed expectations.

module tb_data_io_stream;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       sck      = 1'b0;
   logic       ss       = 1'b1;
   logic       sdi      = 1'b0;
   logic       wait_req = 1'b0;
   logic [1:0] sel      = 2'd0;

   always #5 clk = ~clk;

   logic ss8, sck8, ss16, sck16, ss4, sck4;
   assign ss8   = (sel == 2'd0) ? ss  : 1'b1;
   assign sck8  = (sel == 2'd0) ? sck : 1'b0;
   assign ss16  = (sel == 2'd1) ? ss  : 1'b1;
   assign sck16 = (sel == 2'd1) ? sck : 1'b0;
   assign ss4   = (sel == 2'd2) ? ss  : 1'b1;
   assign sck4  = (sel == 2'd2) ? sck : 1'b0;

   logic        dl8, wr8, ovf8;
   logic [7:0]  idx8;
   logic [15:0] size8, a8;
   logic [7:0]  d8;
   logic        dl16, wr16, ovf16;
   logic [7:0]  idx16;
   logic [15:0] size16, a16, d16;
   logic        dl4, wr4, ovf4;
   logic [7:0]  idx4;
   logic [3:0]  size4, a4;
   logic [7:0]  d4;

   data_io_stream #(.AW(16), .DW(8), .START_ADDR(16'h0000)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .sck(sck8), .ss(ss8), .sdi(sdi),
      .downloading(dl8), .index(idx8), .size(size8), .wr(wr8), .addr(a8),
      .dout(d8), .wait_req(wait_req), .overflow(ovf8)
   );

   data_io_stream #(.AW(16), .DW(16), .START_ADDR(16'h0100)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .sck(sck16), .ss(ss16), .sdi(sdi),
      .downloading(dl16), .index(idx16), .size(size16), .wr(wr16), .addr(a16),
      .dout(d16), .wait_req(wait_req), .overflow(ovf16)
   );

   data_io_stream #(.AW(4), .DW(8), .START_ADDR(4'h0)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .sck(sck4), .ss(ss4), .sdi(sdi),
      .downloading(dl4), .index(idx4), .size(size4), .wr(wr4), .addr(a4),
      .dout(d4), .wait_req(wait_req), .overflow(ovf4)
   );

   typedef struct packed {
      logic [1:0]  inst;
      logic [15:0] a;
      logic [15:0] d;
      logic        dl;
      logic [63:0] t;
   } wr_rec_t;

   wr_rec_t wq[$];

   always @(negedge clk) begin
      if (wr8)  wq.push_back('{inst: 2'd0, a: a8, d: 16'(d8), dl: dl8, t: $time});
      if (wr16) wq.push_back('{inst: 2'd1, a: a16, d: d16, dl: dl16, t: $time});
      if (wr4)  wq.push_back('{inst: 2'd2, a: 16'(a4), d: 16'(d4), dl: dl4, t: $time});
   end

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [63:0] last_rise = 64'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Pops the oldest logged write and checks it; with lat set, the write must
   // land exactly 4 clk after the SCK edge (2 sync stages, push, FIFO).
   task automatic expect_wr(input logic [1:0] inst, input string name, input logic [15:0] ea,
                            input logic [15:0] ed, input bit lat, input logic [63:0] rise);
      wr_rec_t r;
      if (wq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no write seen, want addr %0h data %0h", name, ea, ed);
      end else begin
         r = wq.pop_front();
         chk({name, "_inst"}, 32'(r.inst), 32'(inst));
         chk({name, "_addr"}, 32'(r.a), 32'(ea));
         chk({name, "_data"}, 32'(r.d), 32'(ed));
         chk({name, "_dl"}, 32'(r.dl), 32'd1);
         if (lat) chk({name, "_lat"}, 32'(r.t - rise), 32'd40);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sdi = b[i];
         #40 sck = 1'b1;
         last_rise = $time;
         #40 sck = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 8);
   endtask

   task automatic frame_begin();
      ss = 1'b0;
      #40;
   endtask

   task automatic frame_end();
      #40 ss = 1'b1;
      #80;
   endtask

   task automatic frame1(input logic [7:0] cmd, input logic [7:0] pay);
      frame_begin();
      send_byte(cmd);
      send_byte(pay);
      frame_end();
   endtask

   typedef struct {
      logic [7:0]  din;
      logic [15:0] exp_addr;
      logic [15:0] exp_dout;
   } vec_t;

   vec_t        vec1[3];
   logic [63:0] rise1[3];
   logic [63:0] rise_b, rise_e;

   initial begin
      vec1[0] = '{din: 8'hAA, exp_addr: 16'h0000, exp_dout: 16'h00AA};
      vec1[1] = '{din: 8'hBB, exp_addr: 16'h0001, exp_dout: 16'h00BB};
      vec1[2] = '{din: 8'hCC, exp_addr: 16'h0002, exp_dout: 16'h00CC};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_dl", 32'(dl8), 32'd0);
      chk("rst_wr", 32'(wr8), 32'd0);
      chk("rst_size", 32'(size8), 32'd0);
      chk("rst_ovf", 32'(ovf8), 32'd0);
      chk("rst_index", 32'(idx8), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Basic DW=8 download
      frame1(8'h53, 8'h01);
      chk("t1_dl_start", 32'(dl8), 32'd1);
      frame_begin();
      send_byte(8'h54);
      for (int i = 0; i < 3; i++) begin
         send_byte(vec1[i].din);
         rise1[i] = last_rise;
      end
      frame_end();
      frame1(8'h53, 8'h00);
      repeat (20) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         expect_wr(2'd0, $sformatf("t1_wr%0d", i), vec1[i].exp_addr, vec1[i].exp_dout, 1'b1,
                   rise1[i]);
      end
      chk("t1_size", 32'(size8), 32'd3);
      chk("t1_dl_end", 32'(dl8), 32'd0);
      chk("t1_no_extra", wq.size(), 32'd0);

      // DW=16 packing with flush of a partial word
      sel = 2'd1;
      frame1(8'h53, 8'h01);
      frame_begin();
      send_byte(8'h54);
      send_byte(8'h11);
      send_byte(8'h22);
      rise_b = last_rise;
      send_byte(8'h33);
      frame_end();
      chk("t2_dl_mid", 32'(dl16), 32'd1);
      chk("t2_one_word", wq.size(), 32'd1);
      frame_begin();
      send_byte(8'h53);
      send_byte(8'h00);
      rise_e = last_rise;
      frame_end();
      repeat (20) @(negedge clk);
      expect_wr(2'd1, "t2_w0", 16'h0100, 16'h2211, 1'b1, rise_b);
      expect_wr(2'd1, "t2_w1", 16'h0102, 16'h0033, 1'b1, rise_e);
      chk("t2_dl_end", 32'(dl16), 32'd0);
      chk("t2_size", 32'(size16), 32'd3);

      // Back-pressure and overflow
      sel = 2'd0;
      wait_req = 1'b1;
      frame1(8'h53, 8'h01);
      frame_begin();
      send_byte(8'h54);
      for (int i = 1; i <= 4; i++) send_byte(8'(i));
      frame_end();
      repeat (10) @(negedge clk);
      chk("t3_ovf", 32'(ovf8), 32'd1);
      chk("t3_size", 32'(size8), 32'd4);
      chk("t3_no_wr", wq.size(), 32'd0);
      wait_req = 1'b0;
      repeat (5) @(negedge clk);
      expect_wr(2'd0, "t3_w0", 16'h0000, 16'h0001, 1'b0, 64'd0);
      expect_wr(2'd0, "t3_w1", 16'h0001, 16'h0002, 1'b0, 64'd0);
      chk("t3_no_more", wq.size(), 32'd0);
      frame1(8'h53, 8'h01);
      chk("t3_ovf_clr", 32'(ovf8), 32'd0);

      // File index, and data while not downloading
      frame1(8'h55, 8'h07);
      chk("t4_index", 32'(idx8), 32'd7);
      chk("t4_dl_kept", 32'(dl8), 32'd1);
      frame1(8'h53, 8'h00);
      repeat (5) @(negedge clk);
      chk("t4_dl_end", 32'(dl8), 32'd0);
      frame_begin();
      send_byte(8'h54);
      send_byte(8'h99);
      send_byte(8'h98);
      frame_end();
      repeat (10) @(negedge clk);
      chk("t4_no_wr", wq.size(), 32'd0);
      chk("t4_size", 32'(size8), 32'd0);

      // AW=4: address wrap and size saturation
      sel = 2'd2;
      frame1(8'h53, 8'h01);
      frame_begin();
      send_byte(8'h54);
      for (int i = 0; i < 18; i++) send_byte(8'(8'h10 + i));
      frame_end();
      repeat (10) @(negedge clk);
      for (int i = 0; i < 18; i++) begin
         expect_wr(2'd2, $sformatf("t5_w%0d", i), 16'(i % 16), 16'(8'h10 + i), 1'b0, 64'd0);
      end
      chk("t5_size", 32'(size4), 32'd15);
      chk("t5_ovf", 32'(ovf4), 32'd0);

      // Aborted partial byte
      sel = 2'd0;
      frame1(8'h53, 8'h01);
      frame_begin();
      send_byte(8'h54);
      send_byte(8'h33);
      send_bits(8'hFF, 5);
      frame_end();
      frame1(8'h54, 8'h5A);
      repeat (10) @(negedge clk);
      expect_wr(2'd0, "t6_w0", 16'h0000, 16'h0033, 1'b0, 64'd0);
      expect_wr(2'd0, "t6_w1", 16'h0001, 16'h005A, 1'b0, 64'd0);
      chk("t6_no_more", wq.size(), 32'd0);
      chk("t6_size", 32'(size8), 32'd2);

      // Reset in the middle of a frame with a word held in the FIFO
      wait_req = 1'b1;
      frame1(8'h54, 8'hAB);
      repeat (5) @(negedge clk);
      chk("t7_dout_held", 32'(d8), 32'h0000_00AB);
      chk("t7_addr_held", 32'(a8), 32'd2);
      ss = 1'b0;
      #40;
      send_bits(8'h53, 3);
      #3 reset_n = 1'b0;
      #1;
      chk("t7_rst_dl", 32'(dl8), 32'd0);
      chk("t7_rst_index", 32'(idx8), 32'd0);
      chk("t7_rst_size", 32'(size8), 32'd0);
      chk("t7_rst_wr", 32'(wr8), 32'd0);
      chk("t7_rst_addr", 32'(a8), 32'd0);
      chk("t7_rst_dout", 32'(d8), 32'd0);
      chk("t7_rst_ovf", 32'(ovf8), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
